// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key tracker.
//   - Prefix / control byte values seen on the keyboard link
//   - Arrow-key scan codes
//   - Frame receiver state enum
//   - is_ctrl_byte(): bytes that are neither prefixes nor keys
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [7:0] PS2_UP     = 8'h75;
  localparam logic [7:0] PS2_DOWN   = 8'h72;

  typedef enum logic [1:0] {
    RxIdle,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  // Keyboard housekeeping replies; never treated as key codes.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND) ||
           (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Held-key and receive-status bundle produced by ps2_key_tracker.
//   key1_on/key1_code/key1_ext : slot 1 held flag, scan code, E0 flag
//   key2_on/key2_code/key2_ext : slot 2 held flag, scan code, E0 flag
//   rx_valid/rx_byte           : good-frame pulse and last good byte
//   rx_error                   : bad-frame / timeout pulse
// master = tracker side (drives), slave = consumer side.
interface ps2_key_tracker_if;
  logic       key1_on;
  logic [7:0] key1_code;
  logic       key1_ext;
  logic       key2_on;
  logic [7:0] key2_code;
  logic       key2_ext;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;

  modport master (
    output key1_on, key1_code, key1_ext, key2_on, key2_code, key2_ext,
    output rx_valid, rx_byte, rx_error
  );

  modport slave (
    input key1_on, key1_code, key1_ext, key2_on, key2_code, key2_ext,
    input rx_valid, rx_byte, rx_error
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-flop synchronizers, ps2_clk glitch filter, frame FSM, timeout.
//   clock, resetn      : system clock, async active-low reset
//   ps2_clk, ps2_dat   : raw asynchronous PS/2 lines
//   rx_valid, rx_byte  : one-cycle good-frame pulse, last good byte
//   rx_error           : one-cycle pulse on start/parity/stop error or timeout
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_error
);

  localparam int unsigned FcW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TcW = $clog2(TIMEOUT_CYCLES + 1);

  logic           clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic           filt_q, filt_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic           edge_any, edge_fall;
  rx_state_e      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_ok_q, par_ok_d;
  logic [TcW-1:0] tmo_q, tmo_d;
  logic           rx_valid_q, rx_valid_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           rx_error_q, rx_error_d;

  // Accept a new ps2_clk level only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d    = filt_q;
    fcnt_d    = '0;
    edge_any  = 1'b0;
    edge_fall = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FcW'(FILTER_LEN - 1)) begin
        filt_d    = clk_sync_q;
        edge_any  = 1'b1;
        edge_fall = ~clk_sync_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_error_d = 1'b0;
    // Saturating idle counter, cleared by any filtered edge.
    if (edge_any) begin
      tmo_d = '0;
    end else if (tmo_q == TcW'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if ((state_q != RxIdle) && (tmo_q == TcW'(TIMEOUT_CYCLES))) begin
      state_d    = RxIdle;
      rx_error_d = 1'b1;
    end else if (edge_fall) begin
      unique case (state_q)
        RxIdle: begin
          if (!dat_sync_q) begin
            state_d   = RxData;
            bit_cnt_d = 3'd0;
          end else begin
            rx_error_d = 1'b1;
          end
        end
        RxData: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RxParity;
        end
        RxParity: begin
          par_ok_d = ^{shift_q, dat_sync_q};
          state_d  = RxStop;
        end
        RxStop: begin
          state_d = RxIdle;
          if (dat_sync_q && par_ok_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            rx_error_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= RxIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_ok_q   <= 1'b0;
      tmo_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_error_q <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      tmo_q      <= tmo_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;
  assign rx_error = rx_error_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard decoder tracking up to two held keys in fixed slots.
//   clock, resetn    : system clock, async active-low reset
//   ps2_clk, ps2_dat : raw PS/2 lines
//   key_if (master)  : slot outputs key{1,2}_{on,code,ext} plus rx_valid/rx_byte/rx_error
// Slots never shift: a released slot stays empty until the next new make fills it.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  ps2_key_tracker_if.master   key_if
);

  logic       rx_valid, rx_error;
  logic [7:0] rx_byte;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock   (clock),
    .resetn  (resetn),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .rx_error(rx_error)
  );

  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [2:0]      skip_q, skip_d;
  logic [1:0]      on_q, on_d;
  logic [1:0][7:0] code_q, code_d;
  logic [1:0]      sext_q, sext_d;
  logic [1:0]      hit;

  // A key matches a slot only on the full {ext, code} pair.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i] = on_q[i] && (code_q[i] == rx_byte) && (sext_q[i] == ext_q);
    end
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    on_d   = on_q;
    code_d = code_q;
    sext_d = sext_q;
    if (rx_error) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = 3'd0;
    end else if (rx_valid) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (rx_byte == PS2_PAUSE) begin
        skip_d = 3'd7;  // swallow the rest of the 8-byte pause sequence
      end else if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!is_ctrl_byte(rx_byte)) begin
          if (brk_q) begin
            on_d = on_q & ~hit;
          end else if (hit == 2'b00) begin
            if (!on_q[0]) begin
              on_d[0]   = 1'b1;
              code_d[0] = rx_byte;
              sext_d[0] = ext_q;
            end else if (!on_q[1]) begin
              on_d[1]   = 1'b1;
              code_d[1] = rx_byte;
              sext_d[1] = ext_q;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= 3'd0;
      on_q   <= '0;
      code_q <= '0;
      sext_q <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      skip_q <= skip_d;
      on_q   <= on_d;
      code_q <= code_d;
      sext_q <= sext_d;
    end
  end

  assign key_if.key1_on   = on_q[0];
  assign key_if.key1_code = code_q[0];
  assign key_if.key1_ext  = sext_q[0];
  assign key_if.key2_on   = on_q[1];
  assign key_if.key2_code = code_q[1];
  assign key_if.key2_ext  = sext_q[1];
  assign key_if.rx_valid  = rx_valid;
  assign key_if.rx_byte   = rx_byte;
  assign key_if.rx_error  = rx_error;

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- PS/2 keyboard receiver and decoder. Produces the two-key held-note interface `key1_on`/`key1_code` and `key2_on`/`key2_code`, which the synthesizer state and voice logic consume.
- Deserialises PS/2 frames and interprets the make, break (F0), extended (E0) and pause (E1) prefixes.
- Tracks up to two simultaneously held keys in priority slots.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before a `ps2_clk` level change is accepted.
- TIMEOUT_CYCLES, 50000: system clocks without a filtered `ps2_clk` falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_dat  in  1  raw PS/2 data, asynchronous
- key1_on  out  1  slot 1 key held
- key1_code  out  8  slot 1 scan code
- key1_ext  out  1  slot 1 code was E0-prefixed
- key2_on  out  1  slot 2 key held
- key2_code  out  8  slot 2 scan code
- key2_ext  out  1  slot 2 code was E0-prefixed
- rx_valid  out  1  one-cycle pulse: `rx_byte` is a good frame
- rx_byte  out  8  last good byte
- rx_error  out  1  one-cycle pulse: parity, start or stop error, or timeout

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous, active-low on `resetn`; all outputs are 0 while it is asserted, and the filter state, FSMs and prefix flags are cleared.
- Input synchronisation: `ps2_clk` and `ps2_dat` each pass through a 2-flop synchronizer. `ps2_clk` then passes through the FILTER_LEN glitch filter. A bit is sampled from synced `ps2_dat` on each filtered falling edge.
- Frame FSM states:
  - RX_IDLE: a falling edge with dat=0 goes to RX_DATA. A falling edge with dat=1 pulses `rx_error` and stays in RX_IDLE.
  - RX_DATA: 8 bits, LSB first.
  - RX_PARITY: odd parity over data plus parity bit.
  - RX_STOP: the stop bit must be 1.
- Frame completion: on the stop-bit edge the FSM returns to RX_IDLE. On a good frame, `rx_valid` pulses and `rx_byte` updates in the cycle after the stop-edge sample. On a bad frame, `rx_error` pulses and the byte is discarded.
- Timeout: a counter resets on every filtered edge. When it reaches TIMEOUT_CYCLES outside RX_IDLE, `rx_error` pulses and the FSM returns to RX_IDLE.
- Decode prefix flags: `ext`, `brk`, and `skip` (a 0-7 count). Each is consumed by the next non-prefix byte.
- Decode rules, applied per good byte:
  - `skip` > 0: decrement and ignore the byte.
  - E1: `skip` = 7 (pause sequence discarded).
  - E0: `ext` = 1.
  - F0: `brk` = 1.
  - AA, FA, EE, FE, 00, FF: ignored, and `ext`/`brk` are cleared.
  - Any other byte is key {`ext`, code}. After it is processed, `ext` = `brk` = 0.
- Make (`brk` = 0):
  - Key already held in a slot (typematic repeat): no change.
  - Else slot 1 free: load slot 1, `key1_on` = 1.
  - Else slot 2 free: load slot 2, `key2_on` = 1.
  - Else (both full): the key is ignored.
- Break (`brk` = 1): clear the `on` bit of the slot whose {ext, code} matches; the code and ext outputs retain their values. A break for an unheld key is ignored.
- Slot latency: slot outputs change in the cycle after the `rx_valid` pulse. `code` and `ext` are stable no later than the cycle `on` rises.
- Slot independence: slots never shift. Releasing slot 1 while slot 2 is held leaves slot 2 unchanged, and the next make fills slot 1.
- Receive errors: `rx_error` clears `ext`, `brk` and `skip`; slot state is unchanged.
- Reset during a frame: the partial byte is dropped and both slots are cleared.

Decomposition:
- Shared package `ps2_pkg`, containing:
  - Prefix and control byte constants: PS2_EXT=E0, PS2_BREAK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_ECHO=EE, PS2_RESEND=FE.
  - Arrow codes: PS2_UP=75, PS2_DOWN=72.
  - Frame-state enum.
- Sub-module `ps2_rx`: synchronizer, filter, frame FSM and timeout; outputs `rx_valid`, `rx_byte`, `rx_error`.
- `ps2_key_tracker` instantiates `ps2_rx` and adds the prefix decoder and the two slots.

Test Plan:
- Frame 1C (bits 0,00111000,parity 0,1) then F0, 1C → `key1_on` rises with `key1_code`=1C, `key1_ext`=0; after the break `key1_on`=0 and `key1_code` stays 1C.
- Makes 1C, 1B, 23 then break 1C, then make 2B → slot1=1C, slot2=1B, 23 ignored; after the break `key1_on`=0 and `key2_on`=1 (1B); 2B loads slot 1.
- E0 75 → `key1_code`=75, `key1_ext`=1; E0 F0 75 clears it; a plain F0 75 while E0 75 is held is ignored.
- Frame 1C with parity bit 1 → `rx_error` pulse, no `rx_valid`, slots unchanged; a following F0 with bad stop bit → the next byte is still treated as a make.
- Five bits of a frame then idle for TIMEOUT_CYCLES → `rx_error` pulse; the next full frame 1C is received correctly.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → no slot change; repeated make 1C (typematic) → a single `key1_on` rise with no toggling; a 2-cycle `ps2_clk` glitch → no bit sampled.
